// File: rtl/reg_file_scoreboard_if.sv
// Shared widths for the register file plus the decode/writeback bus it serves.
// Master is the pipeline (decode + writeback); slave is reg_file_scoreboard.
package constants_pkg;
  localparam int WIDTH          = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_COUNT      = 32;
endpackage

interface reg_file_scoreboard_if;
  import constants_pkg::*;

  logic                      issue_valid;
  logic [REG_ADDR_WIDTH-1:0] issue_rd_address;
  logic                      rs_used;
  logic                      rt_used;
  logic [REG_ADDR_WIDTH-1:0] rs_address;
  logic [REG_ADDR_WIDTH-1:0] rt_address;
  logic [WIDTH-1:0]          rs_data;
  logic [WIDTH-1:0]          rt_data;
  logic                      rs_busy;
  logic                      rt_busy;
  logic                      hazard;
  logic                      issue_accepted;
  logic                      rd_wb;
  logic [REG_ADDR_WIDTH-1:0] rd_address_wb;
  logic [WIDTH-1:0]          rd_data_wb;

  modport master (
    output issue_valid, issue_rd_address, rs_used, rt_used, rs_address, rt_address,
    output rd_wb, rd_address_wb, rd_data_wb,
    input  rs_data, rt_data, rs_busy, rt_busy, hazard, issue_accepted
  );

  modport slave (
    input  issue_valid, issue_rd_address, rs_used, rt_used, rs_address, rt_address,
    input  rd_wb, rd_address_wb, rd_data_wb,
    output rs_data, rt_data, rs_busy, rt_busy, hazard, issue_accepted
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Register file with per-register pending-write counters; r0 reads as zero.
// Latency: reads/hazard combinational, writes and counters land on the edge.
// Backpressure: hazard stalls decode, which re-presents; optional REG_FILE_BYPASS_EN forwards writeback.
module reg_file_scoreboard
  import constants_pkg::*;
#(
  parameter int PEND_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_file_scoreboard_if.slave bus,
  output logic [WIDTH-1:0]     reg_file [0:REG_COUNT-2],
  output logic                 sb_error
);

  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

  // Entry 0 of both arrays is never written, so it stays zero after reset.
  logic [WIDTH-1:0]      regs [0:REG_COUNT-1];
  logic [PEND_WIDTH-1:0] cnt  [0:REG_COUNT-1];

  logic inc_en, dec_en, same_reg, ovf, unf;

  function automatic logic [WIDTH-1:0] read_reg(input logic [REG_ADDR_WIDTH-1:0] a,
                                                input logic [WIDTH-1:0]          stored);
    logic [WIDTH-1:0] v;
    v = '0;
    if (a != '0) begin
      v = stored;
`ifdef REG_FILE_BYPASS_EN
      if (bus.rd_wb && bus.rd_address_wb == a) v = bus.rd_data_wb;
`endif
    end
    return v;
  endfunction

  function automatic logic busy_of(input logic [REG_ADDR_WIDTH-1:0] a,
                                   input logic [PEND_WIDTH-1:0]     c);
    logic b;
    b = (a != '0) && (c != '0);
`ifdef REG_FILE_BYPASS_EN
    // The last outstanding write completing this cycle no longer blocks.
    if (bus.rd_wb && bus.rd_address_wb == a && c == PEND_ONE) b = 1'b0;
`endif
    return b;
  endfunction

  always_comb begin
    bus.rs_data        = read_reg(bus.rs_address, regs[bus.rs_address]);
    bus.rt_data        = read_reg(bus.rt_address, regs[bus.rt_address]);
    bus.rs_busy        = busy_of(bus.rs_address, cnt[bus.rs_address]);
    bus.rt_busy        = busy_of(bus.rt_address, cnt[bus.rt_address]);
    bus.hazard         = (bus.rs_used & bus.rs_busy) | (bus.rt_used & bus.rt_busy);
    bus.issue_accepted = bus.issue_valid & ~bus.hazard & ~rst;
  end

  always_comb begin
    for (int i = 0; i < REG_COUNT - 1; i++) reg_file[i] = regs[i+1];
  end

  // Increment and decrement of the same register cancel without error checks.
  always_comb begin
    inc_en   = bus.issue_accepted && (bus.issue_rd_address != '0);
    dec_en   = bus.rd_wb && (bus.rd_address_wb != '0);
    same_reg = inc_en && dec_en && (bus.issue_rd_address == bus.rd_address_wb);
    ovf      = inc_en && !same_reg && (cnt[bus.issue_rd_address] == PEND_MAX);
    unf      = dec_en && !same_reg && (cnt[bus.rd_address_wb] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      sb_error <= 1'b0;
    end else begin
      if (dec_en) regs[bus.rd_address_wb] <= bus.rd_data_wb;
      if (inc_en && !same_reg && !ovf)
        cnt[bus.issue_rd_address] <= cnt[bus.issue_rd_address] + PEND_ONE;
      if (dec_en && !same_reg && !unf)
        cnt[bus.rd_address_wb] <= cnt[bus.rd_address_wb] - PEND_ONE;
      sb_error <= sb_error | ovf | unf;
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench: stimulus pushes expectations into a queue, a negedge monitor pops and compares.
module tb_reg_file_scoreboard;
  import constants_pkg::*;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_RS_DATA = 0, K_RT_DATA = 1, K_RS_BUSY = 2, K_RT_BUSY = 3,
                 K_HAZARD = 4, K_ACCEPT = 5, K_SB_ERR = 6, K_REGF = 7;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [WIDTH-1:0] reg_file [0:REG_COUNT-2];
  logic sb_error;

  reg_file_scoreboard_if bus ();

  reg_file_scoreboard #(.PEND_WIDTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .reg_file (reg_file),
    .sb_error (sb_error)
  );

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          tests  = 0;
  int          failed = 0;

  always @(negedge clk) begin
    while (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      case (mon_e.kind)
        K_RS_DATA: mon_act = bus.rs_data;
        K_RT_DATA: mon_act = bus.rt_data;
        K_RS_BUSY: mon_act = {31'd0, bus.rs_busy};
        K_RT_BUSY: mon_act = {31'd0, bus.rt_busy};
        K_HAZARD:  mon_act = {31'd0, bus.hazard};
        K_ACCEPT:  mon_act = {31'd0, bus.issue_accepted};
        K_SB_ERR:  mon_act = {31'd0, sb_error};
        default:   mon_act = reg_file[mon_e.idx];
      endcase
      tests++;
      if (mon_act !== mon_e.exp) begin
        failed++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic chk(input string name, input int kind, input int idx, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.kind = kind; e.idx = idx; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Advance one cycle and return all inputs to idle.
  task automatic step();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_rd_address = '0;
    bus.rs_used = 1'b0; bus.rt_used = 1'b0;
    bus.rs_address = '0; bus.rt_address = '0;
    bus.rd_wb = 1'b0; bus.rd_address_wb = '0; bus.rd_data_wb = '0;
  endtask

  task automatic issue(input int rd);
    bus.issue_valid = 1'b1; bus.issue_rd_address = 5'(rd);
  endtask

  task automatic wb(input int rd, input logic [31:0] d);
    bus.rd_wb = 1'b1; bus.rd_address_wb = 5'(rd); bus.rd_data_wb = d;
  endtask

  initial begin
    step();
    // Reset cycle with an issue and writeback that must be discarded.
    rst = 1'b1; issue(5); wb(6, 32'h66);
    chk("accept_in_reset", K_ACCEPT, 0, 0);

    step();
    bus.rs_address = 5; bus.rt_address = 31; bus.rs_used = 1; bus.rt_used = 1;
    chk("reset_rs_r5", K_RS_DATA, 0, 0);
    chk("reset_rt_r31", K_RT_DATA, 0, 0);
    chk("reset_hazard", K_HAZARD, 0, 0);
    chk("reset_rs_busy", K_RS_BUSY, 0, 0);
    chk("reset_sb_error", K_SB_ERR, 0, 0);
    chk("reset_wb_dropped", K_REGF, 5, 0);

    step();
    wb(0, 32'hDEADBEEF);
    chk("r0_read_during_wr", K_RS_DATA, 0, 0);

    step();
    chk("r0_read_after_wr", K_RS_DATA, 0, 0);
    chk("r0_wr_regf0", K_REGF, 0, 0);
    chk("r0_wr_regf30", K_REGF, 30, 0);
    chk("r0_wr_sb_error", K_SB_ERR, 0, 0);

    step();
    issue(7);
    chk("issue_r7", K_ACCEPT, 0, 1);

    step();
    wb(7, 32'h12345678); bus.rs_address = 7;
    chk("r7_same_cycle", K_RS_DATA, 0, BYP ? 32'h12345678 : 32'h0);
    chk("r7_busy_completing", K_RS_BUSY, 0, BYP ? 0 : 1);
    chk("r7_regf_not_yet", K_REGF, 6, 0);

    step();
    bus.rs_address = 7;
    chk("r7_regf", K_REGF, 6, 32'h12345678);
    chk("r7_read", K_RS_DATA, 0, 32'h12345678);
    chk("r7_busy_clear", K_RS_BUSY, 0, 0);

    step();
    issue(3);
    chk("issue_r3", K_ACCEPT, 0, 1);

    step();
    issue(10); bus.rs_address = 3; bus.rs_used = 1;
    chk("raw_busy", K_RS_BUSY, 0, 1);
    chk("raw_hazard", K_HAZARD, 0, 1);
    chk("raw_accept", K_ACCEPT, 0, 0);

    step();
    issue(10); bus.rs_address = 3; bus.rs_used = 1; wb(3, 32'hA5);
    chk("raw_wb_hazard", K_HAZARD, 0, BYP ? 0 : 1);
    chk("raw_wb_accept", K_ACCEPT, 0, BYP ? 1 : 0);
    chk("raw_wb_rs_data", K_RS_DATA, 0, BYP ? 32'hA5 : 32'h0);

    step();
    bus.rs_address = 3; bus.rs_used = 1;
    if (!BYP) issue(10);
    chk("raw_after_hazard", K_HAZARD, 0, 0);
    chk("raw_after_rs_data", K_RS_DATA, 0, 32'hA5);
    chk("raw_after_accept", K_ACCEPT, 0, BYP ? 0 : 1);

    step();
    issue(11); bus.rt_address = 10; bus.rt_used = 0; bus.rs_address = 0; bus.rs_used = 1;
    chk("unused_rt_busy", K_RT_BUSY, 0, 1);
    chk("unused_hazard", K_HAZARD, 0, 0);
    chk("unused_accept", K_ACCEPT, 0, 1);

    step();
    issue(4);
    chk("r4_issue1", K_ACCEPT, 0, 1);

    step();
    issue(4); wb(4, 32'h1);
    chk("r4_simul_accept", K_ACCEPT, 0, 1);

    step();
    wb(4, 32'h2); bus.rs_address = 4;
    chk("r4_cnt1_busy", K_RS_BUSY, 0, BYP ? 0 : 1);

    step();
    bus.rs_address = 4;
    chk("r4_drained_busy", K_RS_BUSY, 0, 0);
    chk("r4_simul_no_err", K_SB_ERR, 0, 0);

    for (int i = 0; i < 3; i++) begin
      step();
      issue(4);
      chk("r4_fill_accept", K_ACCEPT, 0, 1);
    end

    step();
    issue(4);
    chk("r4_ovf_accept", K_ACCEPT, 0, 1);
    chk("r4_ovf_err_pre", K_SB_ERR, 0, 0);

    step();
    bus.rs_address = 4;
    chk("r4_ovf_err", K_SB_ERR, 0, 1);
    chk("r4_ovf_busy", K_RS_BUSY, 0, 1);

    step(); wb(4, 32'h3);
    step(); wb(4, 32'h4);
    step();
    bus.rs_address = 4;
    chk("r4_held_at_max", K_RS_BUSY, 0, 1);
    step(); wb(4, 32'h5);
    step();
    bus.rs_address = 4;
    chk("r4_empty_busy", K_RS_BUSY, 0, 0);

    step(); issue(2);
    step(); issue(2);
    step();
    rst = 1'b1; wb(2, 32'h55); issue(9);
    chk("mid_reset_accept", K_ACCEPT, 0, 0);

    step();
    bus.rs_address = 2; bus.rs_used = 1;
    chk("mid_reset_regf1", K_REGF, 1, 0);
    chk("mid_reset_busy", K_RS_BUSY, 0, 0);
    chk("mid_reset_hazard", K_HAZARD, 0, 0);
    chk("mid_reset_rs_data", K_RS_DATA, 0, 0);
    chk("mid_reset_err", K_SB_ERR, 0, 0);

    step();
    wb(4, 32'h44);
    chk("unf_err_pre", K_SB_ERR, 0, 0);

    step();
    chk("unf_err", K_SB_ERR, 0, 1);
    chk("unf_data_written", K_REGF, 3, 32'h44);

    step();
    @(posedge clk);
    if (sb_q.size() != 0) begin
      failed++;
      $display("FAIL queue_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
